led_shift_sequencer: RTL

//  Controller and sequencer for the 16-bit LED shift register. Generates its own step tick from clk and

---
 rtl/led_shift_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/led_shift_sequencer.sv
// led_shift_sequencer: 16-bit LED pattern sequencer with a built-in step prescaler.
// Moves the lit pattern in WRAP, BOUNCE or FILL (Johnson) mode under en/dir control.
// Optional lap counter: define LED_SEQ_LAP_CNT_EN to add the lap port and its counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset; the first step only arms the direction, led held
// S_LEFT  | pattern moving toward the MSB
// S_RIGHT | pattern moving toward the LSB
module led_shift_sequencer #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 25000000
`ifdef LED_SEQ_LAP_CNT_EN
  , parameter int LAP_W  = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             tick
`ifdef LED_SEQ_LAP_CNT_EN
  , output logic [LAP_W-1:0] lap
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] LED_INIT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] led_q, led_d;
  state_t           state_q, state_d;
  logic             step;

  // a step happens on the edge where the registered tick meets en
  assign step = tick_q & en;

  // prescaler: free-running 0..TICK_DIV-1, tick registered one cycle after the last count
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // next state and next pattern, evaluated only on a step
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    if (step) begin
      if (state_q == S_IDLE) begin
        // arming step: pick direction, leave the pattern alone
        state_d = dir ? S_LEFT : S_RIGHT;
      end else begin
        case (mode)
          MODE_FILL: begin
            state_d = dir ? S_LEFT : S_RIGHT;
            if (dir) led_d = {led_q[WIDTH-2:0], ~led_q[WIDTH-1]};
            else     led_d = {~led_q[0], led_q[WIDTH-1:1]};
          end
          MODE_BOUNCE: begin
            if (led_q == '0) begin
              // FILL can leave an empty pattern; reseed rather than shifting nothing
              led_d = LED_INIT;
            end else if (state_q == S_LEFT) begin
              if (led_q[WIDTH-1]) begin
                state_d = S_RIGHT;
                led_d   = led_q >> 1;
              end else begin
                led_d   = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                state_d = S_LEFT;
                led_d   = led_q << 1;
              end else begin
                led_d   = led_q >> 1;
              end
            end
          end
          default: begin
            // WRAP, and the unused mode encoding behaves the same way
            if (led_q == '0) begin
              led_d = LED_INIT;
            end else begin
              state_d = dir ? S_LEFT : S_RIGHT;
              if (dir) led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
              else     led_d = {led_q[0], led_q[WIDTH-1:1]};
            end
          end
        endcase
      end
    end
  end

  // state, pattern and prescaler registers; reset has priority over a coincident step
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      led_q   <= LED_INIT;
      state_q <= S_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      state_q <= state_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

`ifdef LED_SEQ_LAP_CNT_EN
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             wrap_out;
  logic             bounce_rev;
  logic             lap_inc;

  // a lap is a WRAP carry across the pattern ends or a BOUNCE reversal; FILL and arming never count
  always_comb begin
    wrap_out   = (mode != MODE_BOUNCE) && (mode != MODE_FILL) &&
                 (dir ? led_q[WIDTH-1] : led_q[0]);
    bounce_rev = (mode == MODE_BOUNCE) &&
                 ((state_q == S_LEFT) ? led_q[WIDTH-1] : led_q[0]);
    lap_inc    = step && (state_q != S_IDLE) && (wrap_out || bounce_rev);
    lap_d      = lap_inc ? (lap_q + LAP_W'(1)) : lap_q;
  end

  // lap counter register, wraps naturally at 2^LAP_W
  always_ff @(posedge clk) begin
    if (rst) lap_q <= '0;
    else     lap_q <= lap_d;
  end

  assign lap = lap_q;
`endif

endmodule
